// File: rtl/evt_sched_pkg.sv
// Shared types and helpers for the round-robin event scheduler.
package evt_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int DEFAULT_TIMEOUT = 16;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set pending bit at or after ptr, wrapping modulo N_REQ.
module rr_pick
  import evt_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx,
  output logic [N_REQ-1:0] onehot
);

  localparam logic [ID_W:0] N_VAL = (ID_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] doubled;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rotated;
  logic [ID_W-1:0]    offset;
  logic [ID_W:0]      sum;

  // Rotating a doubled copy right by ptr puts requester ptr at bit 0.
  assign doubled = {pending, pending};
  assign shifted = doubled >> ptr;
  assign rotated = shifted[N_REQ-1:0];
  assign found   = |rotated;

  always_comb begin
    offset = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) offset = ID_W'(k);
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, offset};
  assign idx = (sum >= N_VAL) ? ID_W'(sum - N_VAL) : sum[ID_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign onehot[gi] = found && (idx == ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/evt_rr_scheduler.sv
// Round-robin event scheduler: latches event pulses as pending and grants them one at a time.
// Optional grant abort after TIMEOUT cycles without ack is enabled by defining EVT_SCHED_TIMEOUT_EN.
module evt_rr_scheduler
  import evt_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
`ifdef EVT_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic                          gnt_valid_o,
  output logic [id_width(N_REQ)-1:0]    gnt_id_o,
  input  logic                          gnt_ack_i,
  output logic [N_REQ-1:0]              pend_o,
  output logic                          busy_o,
  output logic [CNT_W-1:0]              evt_cnt_o,
  output logic                          timeout_o
);

  localparam int ID_W = id_width(N_REQ);

  state_t             state_reg,   state_next;
  logic [N_REQ-1:0]   pending_reg, pending_next;
  logic [ID_W-1:0]    ptr_reg,     ptr_next;
  logic [N_REQ-1:0]   gnt_reg,     gnt_next;
  logic [ID_W-1:0]    gnt_id_reg,  gnt_id_next;
  logic [CNT_W-1:0]   evt_cnt_reg, evt_cnt_next;
  logic [N_REQ-1:0]   clear_mask;
  logic [ID_W-1:0]    after_id;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic [N_REQ-1:0]   pick_onehot;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .pending (pending_reg),
    .ptr     (ptr_reg),
    .found   (pick_found),
    .idx     (pick_idx),
    .onehot  (pick_onehot)
  );

  assign after_id = (gnt_id_reg == ID_W'(N_REQ - 1)) ? '0 : gnt_id_reg + 1'b1;

`ifdef EVT_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             timeout_reg, timeout_next;
`endif

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    evt_cnt_next = evt_cnt_reg;
    clear_mask   = '0;
`ifdef EVT_SCHED_TIMEOUT_EN
    tmo_cnt_next = tmo_cnt_reg;
    timeout_next = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_next    = pick_onehot;
          gnt_id_next = pick_idx;
          state_next  = ST_GRANT;
`ifdef EVT_SCHED_TIMEOUT_EN
          tmo_cnt_next = '0;
`endif
        end
      end
      ST_GRANT: begin
        // Ack is tested first so that an ack on the expiry edge completes normally.
        if (gnt_ack_i) begin
          clear_mask   = gnt_reg;
          ptr_next     = after_id;
          evt_cnt_next = evt_cnt_reg + 1'b1;
          gnt_next     = '0;
          gnt_id_next  = '0;
          state_next   = ST_IDLE;
        end
`ifdef EVT_SCHED_TIMEOUT_EN
        else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
          clear_mask   = gnt_reg;
          ptr_next     = after_id;
          gnt_next     = '0;
          gnt_id_next  = '0;
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
    // A new pulse on the completing id re-arms it rather than being lost.
    pending_next = (pending_reg & ~clear_mask) | req_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pending_reg <= '0;
      ptr_reg     <= '0;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      evt_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      ptr_reg     <= ptr_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      evt_cnt_reg <= evt_cnt_next;
    end
  end

`ifdef EVT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign timeout_o = timeout_reg;
`else
  assign timeout_o = 1'b0;
`endif

  assign gnt_o       = gnt_reg;
  assign gnt_valid_o = |gnt_reg;
  assign gnt_id_o    = gnt_id_reg;
  assign pend_o      = pending_reg;
  assign busy_o      = (state_reg != ST_IDLE);
  assign evt_cnt_o   = evt_cnt_reg;

endmodule

// File: tb/tb_evt_rr_scheduler.sv
// Self-checking bench for evt_rr_scheduler: directed scenarios plus randomized traffic against a reference model.
module tb_evt_rr_scheduler;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic [3:0] gnt_o;
  logic       gnt_valid_o;
  logic [1:0] gnt_id_o;
  logic       gnt_ack_i;
  logic [3:0] pend_o;
  logic       busy_o;
  logic [7:0] evt_cnt_o;
  logic       timeout_o;

  evt_rr_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_id_o    (gnt_id_o),
    .gnt_ack_i   (gnt_ack_i),
    .pend_o      (pend_o),
    .busy_o      (busy_o),
    .evt_cnt_o   (evt_cnt_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending set, rotation pointer, current grant, counters.
  bit [3:0] m_pend;
  int       m_ptr;
  bit       m_busy;
  int       m_id;
  int       m_cnt;
  int       m_wait;
  bit       m_tmo;

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_busy = 0; m_id = 0; m_cnt = 0; m_wait = 0; m_tmo = 0;
  endtask

  function automatic logic [3:0] exp_gnt();
    logic [3:0] g;
    g = '0;
    if (m_busy) g[m_id] = 1'b1;
    return g;
  endfunction

  // Drive one cycle of inputs, advance the model at the clock edge, release inputs after it.
  task automatic step(input logic [3:0] req, input logic ack);
    req_i = req;
    gnt_ack_i = ack;
    @(posedge clk);
    m_tmo = 0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_pend[c]) begin
          m_busy = 1; m_id = c; m_wait = 0;
          break;
        end
      end
    end else if (ack) begin
      m_pend[m_id] = 1'b0;
      m_ptr = (m_id + 1) % N;
      m_cnt = (m_cnt + 1) % 256;
      m_busy = 0;
    end
`ifdef EVT_SCHED_TIMEOUT_EN
    else if (m_wait == TMO - 1) begin
      m_pend[m_id] = 1'b0;
      m_ptr = (m_id + 1) % N;
      m_busy = 0;
      m_tmo = 1;
    end else begin
      m_wait++;
    end
`endif
    m_pend = m_pend | req;
    #1;
    req_i = '0;
    gnt_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = '0; gnt_ack_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({gnt_o, gnt_valid_o, gnt_id_o, pend_o, busy_o, evt_cnt_o, timeout_o} !== '0) begin
      n_err++;
      $display("FAIL reset_init: got gnt=%b pend=%b busy=%b cnt=%0d tmo=%b, required all 0",
               gnt_o, pend_o, busy_o, evt_cnt_o, timeout_o);
    end
    @(negedge clk) rst = 1'b0;
    step(4'b1011, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    n_cmp++;
    if (busy_o !== 1'b1 || gnt_id_o !== 2'd1 || evt_cnt_o !== 8'd1 || pend_o !== 4'b1010) begin
      n_err++;
      $display("FAIL reset_pre: got busy=%b id=%0d cnt=%0d pend=%b, required busy=1 id=1 cnt=1 pend=1010",
               busy_o, gnt_id_o, evt_cnt_o, pend_o);
    end
    #2 rst = 1'b1;
    #1;
    $display("reset asserted mid-grant at %0t", $time);
    n_cmp++;
    if ({gnt_o, gnt_valid_o, pend_o, busy_o, evt_cnt_o} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got gnt=%b pend=%b busy=%b cnt=%0d, required all 0",
               gnt_o, pend_o, busy_o, evt_cnt_o);
    end
    model_reset();
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_fairness();
    step(4'b1111, 1'b0);
    n_cmp++;
    if (pend_o !== 4'b1111 || gnt_o !== 4'b0000) begin
      n_err++;
      $display("FAIL fair_latch: got pend=%b gnt=%b, required pend=1111 gnt=0000", pend_o, gnt_o);
    end
    for (int i = 0; i < N; i++) begin
      logic [3:0] g;
      g = 4'b0001 << i;
      step(4'b0000, 1'b0);
      $display("fairness grant id=%0d gnt=%b", gnt_id_o, gnt_o);
      n_cmp++;
      if (gnt_o !== g || gnt_id_o !== 2'(i) || gnt_valid_o !== 1'b1) begin
        n_err++;
        $display("FAIL fair_order: got gnt=%b id=%0d, required gnt=%b id=%0d", gnt_o, gnt_id_o, g, i);
      end
      step(4'b0000, 1'b1);
    end
    n_cmp++;
    if (evt_cnt_o !== 8'd4 || pend_o !== 4'b0000) begin
      n_err++;
      $display("FAIL fair_count: got cnt=%0d pend=%b, required cnt=4 pend=0000", evt_cnt_o, pend_o);
    end
  endtask

  task automatic test_single();
    step(4'b0100, 1'b0);
    n_cmp++;
    if (pend_o !== 4'b0100 || gnt_o !== 4'b0000) begin
      n_err++;
      $display("FAIL single_pend: got pend=%b gnt=%b, required pend=0100 gnt=0000", pend_o, gnt_o);
    end
    step(4'b0000, 1'b0);
    $display("single grant id=%0d gnt=%b", gnt_id_o, gnt_o);
    n_cmp++;
    if (gnt_o !== 4'b0100 || gnt_id_o !== 2'd2 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_gnt: got gnt=%b id=%0d busy=%b, required gnt=0100 id=2 busy=1", gnt_o, gnt_id_o, busy_o);
    end
    step(4'b0000, 1'b1);
    n_cmp++;
    if (evt_cnt_o !== 8'd5 || gnt_o !== 4'b0000 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_ack: got cnt=%0d gnt=%b busy=%b, required cnt=5 gnt=0000 busy=0", evt_cnt_o, gnt_o, busy_o);
    end
  endtask

  // Pointer sits at 3 after the single-event test.
  task automatic test_rotation();
    step(4'b1001, 1'b0);
    step(4'b0000, 1'b0);
    $display("rotation grant id=%0d", gnt_id_o);
    n_cmp++;
    if (gnt_id_o !== 2'd3 || gnt_o !== 4'b1000) begin
      n_err++;
      $display("FAIL rot_first: got id=%0d gnt=%b, required id=3 gnt=1000", gnt_id_o, gnt_o);
    end
    step(4'b0000, 1'b1);
    n_cmp++;
    if (gnt_valid_o !== 1'b0 || pend_o !== 4'b0001) begin
      n_err++;
      $display("FAIL rot_gap: got valid=%b pend=%b, required valid=0 pend=0001", gnt_valid_o, pend_o);
    end
    step(4'b0000, 1'b0);
    $display("rotation grant id=%0d", gnt_id_o);
    n_cmp++;
    if (gnt_id_o !== 2'd0 || gnt_o !== 4'b0001) begin
      n_err++;
      $display("FAIL rot_second: got id=%0d gnt=%b, required id=0 gnt=0001", gnt_id_o, gnt_o);
    end
    step(4'b0000, 1'b1);
  endtask

  // Pointer sits at 1 here.
  task automatic test_collision();
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    n_cmp++;
    if (gnt_o !== 4'b0010 || pend_o !== 4'b0011) begin
      n_err++;
      $display("FAIL coll_hold: got gnt=%b pend=%b, required gnt=0010 pend=0011", gnt_o, pend_o);
    end
    step(4'b0010, 1'b1);
    n_cmp++;
    if (pend_o !== 4'b0011 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL coll_keep: got pend=%b busy=%b, required pend=0011 busy=0", pend_o, busy_o);
    end
    step(4'b0000, 1'b0);
    $display("collision grant id=%0d", gnt_id_o);
    n_cmp++;
    if (gnt_id_o !== 2'd0) begin
      n_err++;
      $display("FAIL coll_other: got id=%0d, required id=0", gnt_id_o);
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    $display("collision grant id=%0d", gnt_id_o);
    n_cmp++;
    if (gnt_id_o !== 2'd1 || gnt_o !== 4'b0010) begin
      n_err++;
      $display("FAIL coll_again: got id=%0d gnt=%b, required id=1 gnt=0010", gnt_id_o, gnt_o);
    end
    step(4'b0000, 1'b1);
  endtask

  task automatic test_timeout();
    int cnt0;
    cnt0 = m_cnt;
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
`ifdef EVT_SCHED_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) begin
      step(4'b0000, 1'b0);
      n_cmp++;
      if (gnt_o !== 4'b0001 || timeout_o !== 1'b0) begin
        n_err++;
        $display("FAIL tmo_hold: cycle %0d got gnt=%b tmo=%b, required gnt=0001 tmo=0", i, gnt_o, timeout_o);
      end
    end
    step(4'b0000, 1'b0);
    $display("timeout abort tmo=%b pend=%b", timeout_o, pend_o);
    n_cmp++;
    if (timeout_o !== 1'b1 || gnt_o !== 4'b0000 || pend_o[0] !== 1'b0 || evt_cnt_o !== 8'(cnt0)) begin
      n_err++;
      $display("FAIL tmo_abort: got tmo=%b gnt=%b pend=%b cnt=%0d, required tmo=1 gnt=0000 pend[0]=0 cnt=%0d",
               timeout_o, gnt_o, pend_o, evt_cnt_o, cnt0);
    end
    step(4'b0000, 1'b0);
    n_cmp++;
    if (timeout_o !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_pulse: got tmo=%b, required 0", timeout_o);
    end
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    repeat (TMO - 1) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    n_cmp++;
    if (timeout_o !== 1'b0 || evt_cnt_o !== 8'(cnt0 + 1) || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_ackwins: got tmo=%b cnt=%0d busy=%b, required tmo=0 cnt=%0d busy=0",
               timeout_o, evt_cnt_o, busy_o, cnt0 + 1);
    end
`else
    for (int i = 0; i < 100; i++) begin
      step(4'b0000, 1'b0);
      n_cmp++;
      if (gnt_o !== 4'b0001 || timeout_o !== 1'b0) begin
        n_err++;
        $display("FAIL tmo_off_hold: cycle %0d got gnt=%b tmo=%b, required gnt=0001 tmo=0", i, gnt_o, timeout_o);
      end
    end
    step(4'b0000, 1'b1);
    n_cmp++;
    if (evt_cnt_o !== 8'(cnt0 + 1) || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_off_ack: got cnt=%0d busy=%b, required cnt=%0d busy=0", evt_cnt_o, busy_o, cnt0 + 1);
    end
`endif
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    while (m_cnt != 255 && guard < 300) begin
      step(4'b0001 << (guard % N), 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b1);
      guard++;
    end
    n_cmp++;
    if (evt_cnt_o !== 8'hFF) begin
      n_err++;
      $display("FAIL wrap_max: got cnt=%0d, required 255", evt_cnt_o);
    end
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    $display("wrap event done cnt=%0d", evt_cnt_o);
    n_cmp++;
    if (evt_cnt_o !== 8'h00) begin
      n_err++;
      $display("FAIL wrap_zero: got cnt=%0d, required 0", evt_cnt_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] req;
      logic       ack;
      req = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      ack = ($urandom_range(0, 2) == 0);
      step(req, ack);
      n_cmp++;
      if (gnt_o !== exp_gnt() || gnt_id_o !== 2'(m_busy ? m_id : 0) || gnt_valid_o !== m_busy ||
          busy_o !== m_busy || pend_o !== m_pend || evt_cnt_o !== 8'(m_cnt) || timeout_o !== m_tmo) begin
        n_err++;
        $display("FAIL rand_cycle %0d: got gnt=%b id=%0d pend=%b busy=%b cnt=%0d tmo=%b, required gnt=%b id=%0d pend=%b busy=%b cnt=%0d tmo=%b",
                 i, gnt_o, gnt_id_o, pend_o, busy_o, evt_cnt_o, timeout_o,
                 exp_gnt(), m_busy ? m_id : 0, m_pend, m_busy, m_cnt, m_tmo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_rotation();
    test_collision();
    test_timeout();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
